// File: rtl/rsa_pkg.sv
// Shared encodings for the modular-exponentiation control path.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE_SQ,
    ISSUE_MUL,
    DONE
  } state_t;

  localparam logic OP_SQ  = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/lead_one_detect.sv
// Combinational leading-one index of a vector, plus an all-zero flag.
module lead_one_detect #(
  parameter int W = 16
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] idx,
  output logic                 zero
);

  localparam int IW = $clog2(W);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign zero = ~|vec;

endmodule

// File: rtl/modexp_sequencer.sv
// Left-to-right binary exponentiation sequencer: walks the captured key and
// issues square/multiply requests to the modmul datapath over valid/ack.
//
// state     | meaning
// IDLE      | waiting for start
// SETUP     | locate leading one of key, pick first bit to process
// ISSUE_SQ  | square request (raised the cycle after entry, held until ack)
// ISSUE_MUL | multiply request (dummy when key bit is 0 in constant-time mode)
// DONE      | one-cycle completion pulse
module modexp_sequencer
  import rsa_pkg::*;
#(
  parameter int KEY_W      = 16,
  parameter int CONST_TIME = 0,
  parameter int CNT_W      = $clog2(2*KEY_W+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [KEY_W-1:0]         key,
  input  logic                     step_ack,
  output logic                     busy,
  output logic                     mux_sel,
  output logic                     op_valid,
  output logic                     op_is_mul,
  output logic                     op_dummy,
  output logic [$clog2(KEY_W)-1:0] bit_idx,
  output logic [CNT_W-1:0]         op_count,
  output logic                     done,
  output logic                     err_zero_key
);

  localparam int BW = $clog2(KEY_W);

  state_t           state, state_nxt;
  logic [KEY_W-1:0] key_q;
  logic [BW-1:0]    lod_idx;
  logic             lod_zero;
  logic             acked;
  logic             want_mul;

  lead_one_detect #(.W(KEY_W)) u_lod (
    .vec  (key_q),
    .idx  (lod_idx),
    .zero (lod_zero)
  );

  assign acked    = op_valid & step_ack;
  assign want_mul = key_q[bit_idx] | (CONST_TIME != 0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = SETUP;
      SETUP:     state_nxt = (lod_zero || lod_idx == '0) ? DONE : ISSUE_SQ;
      ISSUE_SQ:  if (acked) state_nxt = want_mul ? ISSUE_MUL : ((bit_idx == '0) ? DONE : ISSUE_SQ);
      ISSUE_MUL: if (acked) state_nxt = (bit_idx == '0) ? DONE : ISSUE_SQ;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      key_q        <= '0;
      busy         <= 1'b0;
      mux_sel      <= 1'b0;
      op_valid     <= 1'b0;
      op_is_mul    <= 1'b0;
      op_dummy     <= 1'b0;
      bit_idx      <= '0;
      op_count     <= '0;
      done         <= 1'b0;
      err_zero_key <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE) && (state != DONE);
      case (state)
        IDLE: begin
          if (start) begin
            key_q        <= key;
            busy         <= 1'b1;
            mux_sel      <= 1'b0;
            bit_idx      <= '0;
            op_count     <= '0;
            err_zero_key <= 1'b0;
          end
        end
        SETUP: begin
          if (lod_zero) err_zero_key <= 1'b1;
          else if (lod_idx != '0) bit_idx <= lod_idx - BW'(1);
        end
        ISSUE_SQ, ISSUE_MUL: begin
          // Request is raised one cycle after entering the state, which
          // gives the mandatory idle cycle between consecutive ops.
          if (!op_valid) begin
            op_valid  <= 1'b1;
            op_is_mul <= (state == ISSUE_MUL) ? OP_MUL : OP_SQ;
            op_dummy  <= (state == ISSUE_MUL) & ~key_q[bit_idx];
          end else if (step_ack) begin
            op_valid  <= 1'b0;
            op_is_mul <= 1'b0;
            op_dummy  <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            mux_sel   <= 1'b1;
            if (bit_idx != '0 && (state == ISSUE_MUL || !want_mul))
              bit_idx <= bit_idx - BW'(1);
          end
        end
        DONE: begin
          busy    <= 1'b0;
          mux_sel <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
